// File: rtl/axi_lite_cmd_queue.sv
// axi_lite_cmd_queue
// Command FIFO in front of axi_lite_master. Commands are issued one at a time,
// and completion is detected from the B/R channel monitor taps.
// Build macro AXI_CMDQ_TIMEOUT_EN: adds a per-command timeout that forces a
// response with rsp_err=1. Without it, WAIT lasts until completion and rsp_err is 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no command in flight; pops the FIFO head when one is present
// ISSUE | start_* strobe held for START_HOLD cycles; early completion latched
// WAIT  | strobe released, waiting for the matching B or R handshake
// RESP  | response presented until the requester takes it
module axi_lite_cmd_queue #(
    parameter int DEPTH      = 4,
    parameter int START_HOLD = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        aclk,
    input  logic        areset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        start_read,
    output logic        start_write,
    output logic [31:0] addr,
    output logic [31:0] data,
    input  logic        mon_bvalid,
    input  logic        mon_bready,
    input  logic        mon_rvalid,
    input  logic        mon_rready,
    input  logic [31:0] mon_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef struct packed {
        logic  wr;
        addr_t a;
        data_t d;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || START_HOLD < 1 || START_HOLD > 15
        || TIMEOUT < 1) begin : g_param_check
        $error("axi_lite_cmd_queue: illegal parameter set");
    end

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;

    state_t        state_q, state_d;
    logic [3:0]    hold_q, hold_d;
    logic          wr_q, wr_d;
    addr_t         addr_q, addr_d;
    data_t         data_q, data_d;
    logic          done_q, done_d;
    data_t         rdata_q, rdata_d;

    logic          push, pop, empty, full, hit;
    entry_t        head;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && !empty;
    assign head      = mem_q[rd_ptr_q];
    assign hit       = wr_q ? (mon_bvalid && mon_bready) : (mon_rvalid && mon_rready);

`ifdef AXI_CMDQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_q, to_d;
    logic          err_q, err_d;
    logic          expire;

    assign expire  = (to_q == TW'(1));
    assign rsp_err = err_q;

    // Timeout down-counter and error flag.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    // Command storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // FIFO pointers and occupancy; a same-cycle pop never frees room for a push.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sequencer state and issue/response registers.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: pop, strobe hold, completion capture, response handoff.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        rdata_d = rdata_q;
`ifdef AXI_CMDQ_TIMEOUT_EN
        to_d    = to_q;
        err_d   = err_q;
        if ((state_q == S_ISSUE || state_q == S_WAIT) && to_q != '0) begin
            to_d = to_q - TW'(1);
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    wr_d    = head.wr;
                    addr_d  = head.a;
                    data_d  = head.wr ? head.d : '0;
                    hold_d  = 4'(START_HOLD);
                    done_d  = 1'b0;
                    rdata_d = '0;
`ifdef AXI_CMDQ_TIMEOUT_EN
                    to_d    = TW'(TIMEOUT);
                    err_d   = 1'b0;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                hold_d = hold_q - 4'd1;
                if (hit && !done_q) begin
                    done_d  = 1'b1;
                    rdata_d = wr_q ? '0 : mon_rdata;
                end
                if (hold_q == 4'd1) begin
                    state_d = (done_q || hit) ? S_RESP : S_WAIT;
                end
`ifdef AXI_CMDQ_TIMEOUT_EN
                if (expire && !done_q && !hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
`endif
            end
            S_WAIT: begin
                if (hit) begin
                    rdata_d = wr_q ? '0 : mon_rdata;
                    state_d = S_RESP;
                end
`ifdef AXI_CMDQ_TIMEOUT_EN
                else if (expire) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign start_write = (state_q == S_ISSUE) &&  wr_q;
    assign start_read  = (state_q == S_ISSUE) && !wr_q;
    assign addr        = addr_q;
    assign data        = data_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_write   = wr_q;
    assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_cmd_queue.sv
// Randomized bench for axi_lite_cmd_queue with a transaction-level reference model.
module tb_axi_lite_cmd_queue;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int TMO   = 64;

    logic        aclk, areset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        start_read, start_write;
    logic [31:0] addr, data;
    logic        mon_bvalid, mon_bready, mon_rvalid, mon_rready;
    logic [31:0] mon_rdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;

    axi_lite_cmd_queue #(.DEPTH(DEPTH), .START_HOLD(HOLD), .TIMEOUT(TMO)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .start_read(start_read), .start_write(start_write), .addr(addr), .data(data),
        .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
        .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rdata(mon_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
    } cmd_t;

    cmd_t        stim_q[$];
    cmd_t        mq[$];
    cmd_t        cur, push_cmd;
    logic [31:0] smem [logic [31:0]];
    logic [31:0] rsp_log[$];
    bit          rsp_wlog[$];
    bit          rsp_elog[$];

    bit          cur_act = 0, completed = 0, err_exp = 0, pop_pend = 0;
    logic [31:0] rdat_exp = '0, cmp_data = '0;
    int          hold_seen = 0, age = 0;
    bit          push_dec = 0, cmp_dec = 0, rsp_dec = 0;
    int          p_cmd = 100, p_cmp = 30, p_rsp = 100;
    int          n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic add(input bit wr, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.wr = wr; c.a = a; c.d = d;
        stim_q.push_back(c);
    endtask

    function automatic bit busy();
        return stim_q.size() != 0 || mq.size() != 0 || cur_act || pop_pend || push_dec || rsp_dec;
    endfunction

    // One cycle of the model: commit last cycle's decisions, check, then drive.
    task automatic step();
        bit issue, exp_rv, inflight;
        if (push_dec) mq.push_back(push_cmd);
        if (cmp_dec) begin
            completed = 1;
            rdat_exp  = cur.wr ? 32'h0 : cmp_data;
            if (cur.wr) smem[cur.a] = cur.d;
        end
`ifdef AXI_CMDQ_TIMEOUT_EN
        else if (cur_act && !completed) begin
            age++;
            if (age == TMO) begin
                completed = 1; err_exp = 1; rdat_exp = 0;
            end
        end
`endif
        if (rsp_dec) cur_act = 0;
        push_dec = 0; cmp_dec = 0; rsp_dec = 0;

        if (pop_pend) begin
            cur = mq.pop_front();
            cur_act = 1; hold_seen = 0; completed = 0; err_exp = 0; rdat_exp = 0; age = 0;
            pop_pend = 0;
        end

        issue = cur_act && hold_seen < HOLD;
        check("start_write", start_write, issue && cur.wr);
        check("start_read", start_read, issue && !cur.wr);
        check("start_excl", start_write & start_read, 0);
        if (cur_act) begin
            check("addr", addr, cur.a);
            check("data", data, cur.wr ? cur.d : 32'h0);
        end
        if (issue) hold_seen++;
        exp_rv = cur_act && completed && !issue;
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            check("rsp_write", rsp_write, cur.wr);
            check("rsp_rdata", rsp_rdata, rdat_exp);
            check("rsp_err", rsp_err, err_exp);
        end
        check("cmd_ready", cmd_ready, mq.size() < DEPTH);

        pop_pend = !cur_act && mq.size() > 0;

        if (stim_q.size() > 0 && $urandom_range(99) < p_cmd) begin
            cmd_valid = 1; cmd_write = stim_q[0].wr;
            cmd_addr = stim_q[0].a; cmd_wdata = stim_q[0].d;
        end else begin
            cmd_valid = 0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
        end
        push_dec = cmd_valid && cmd_ready;
        if (push_dec) push_cmd = stim_q.pop_front();

        inflight = cur_act && !completed;
        cmp_dec  = inflight && $urandom_range(99) < p_cmp;
        mon_bvalid = $urandom; mon_bready = $urandom;
        mon_rvalid = $urandom; mon_rready = $urandom;
        mon_rdata  = $urandom;
        if (inflight) begin
            if (cur.wr) begin
                mon_bvalid = cmp_dec ? 1'b1 : $urandom;
                mon_bready = cmp_dec ? 1'b1 : (mon_bvalid ? 1'b0 : $urandom);
            end else begin
                mon_rvalid = cmp_dec ? 1'b1 : $urandom;
                mon_rready = cmp_dec ? 1'b1 : (mon_rvalid ? 1'b0 : $urandom);
                if (cmp_dec && smem.exists(cur.a)) mon_rdata = smem[cur.a];
            end
        end
        cmp_data = mon_rdata;

        rsp_ready = $urandom_range(99) < p_rsp;
        rsp_dec   = rsp_valid && rsp_ready;
        if (rsp_dec) begin
            rsp_log.push_back(rsp_rdata);
            rsp_wlog.push_back(rsp_write);
            rsp_elog.push_back(rsp_err);
        end
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            @(negedge aclk); step(); n++;
        end
        check("drain_done", busy(), 0);
        repeat (3) begin @(negedge aclk); step(); end
    endtask

    task automatic run_n(input int n);
        repeat (n) begin @(negedge aclk); step(); end
    endtask

    task automatic check_reset_vals();
        check("rst_start_read", start_read, 0);
        check("rst_start_write", start_write, 0);
        check("rst_addr", addr, 0);
        check("rst_data", data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_write", rsp_write, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cmd_ready", cmd_ready, 1);
    endtask

    task automatic quiet_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        mon_bvalid = 0; mon_bready = 0; mon_rvalid = 0; mon_rready = 0; mon_rdata = 0;
        rsp_ready = 0;
    endtask

    initial begin
        int n;
        areset_n = 0;
        quiet_inputs();
        repeat (3) @(negedge aclk);
        check_reset_vals();
        areset_n = 1;

        // single write
        p_cmd = 100; p_cmp = 30; p_rsp = 100;
        add(1, 32'h0002, 32'hdeadbeef);
        run_drain(200);

        // write then read back through the slave memory
        rsp_log.delete(); rsp_wlog.delete();
        add(1, 32'h0001, 32'h000a);
        add(0, 32'h0001, $urandom);
        run_drain(200);
        check("wr_rd_count", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            check("wr_rd_data", rsp_log[1], 32'h0000000a);
            check("wr_rd_type", rsp_wlog[1], 0);
        end

        // overfill with the master stalled
        p_cmp = 0;
        for (int i = 1; i <= 6; i++) add(1, i, $urandom);
        run_n(10);
        check("full_ready", cmd_ready, 0);
        check("full_left", stim_q.size(), 1);
        p_cmp = 50;
        run_drain(500);

        // response back-pressure after a read
        p_rsp = 0; p_cmp = 40;
        add(0, 32'h0002, 0);
        add(1, 32'h0003, 32'h1234);
        n = 0;
        while (!rsp_valid && n < 60) begin @(negedge aclk); step(); n++; end
        check("bp_rsp_seen", rsp_valid, 1);
        run_n(10);
        p_rsp = 100;
        run_drain(200);

        // asynchronous reset in the middle of WAIT with two entries queued
        p_cmp = 0;
        add(1, 32'h10, 32'h11); add(0, 32'h20, 0); add(1, 32'h30, 32'h33);
        n = 0;
        while (!(cur_act && hold_seen == HOLD && mq.size() == 2) && n < 60) begin
            @(negedge aclk); step(); n++;
        end
        check("rst_mid_reached", mq.size(), 2);
        #2 areset_n = 0;
        #1 check_reset_vals();
        stim_q.delete(); mq.delete();
        cur_act = 0; completed = 0; pop_pend = 0; push_dec = 0; cmp_dec = 0; rsp_dec = 0;
        quiet_inputs();
        @(negedge aclk);
        areset_n = 1;
        run_n(10);
        check("post_rst_ready", cmd_ready, 1);

`ifdef AXI_CMDQ_TIMEOUT_EN
        // timeout with the B channel suppressed, then the next command issues
        rsp_elog.delete();
        p_cmp = 0; p_rsp = 100;
        add(1, 32'h40, 32'h44); add(0, 32'h50, 0);
        run_drain(400);
        check("tmo_count", rsp_elog.size(), 2);
        if (rsp_elog.size() == 2) check("tmo_err", rsp_elog[0], 1);
`endif

        // randomized traffic segments
        for (int s = 0; s < 4; s++) begin
            p_cmd = 20 + $urandom_range(80);
            p_cmp = 10 + $urandom_range(60);
            p_rsp = 20 + $urandom_range(80);
            for (int i = 0; i < 50; i++) add($urandom, {29'h0, 3'($urandom)}, $urandom);
            run_drain(8000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
